// File: rtl/uart_frame_pkg.sv
// Shared framing definitions for the PC UART link (TX serializer and RX assembler).
// Latency: n/a, constants and types only.
// Backpressure: n/a.
package uart_frame_pkg;

    // Frame delimiters; the receive side keys on the same values
    localparam logic [7:0] START_BYTE = 8'hAA;
    localparam logic [7:0] END_BYTE   = 8'h55;

    // Transmit serializer states
    typedef enum logic [3:0] {
        ST_IDLE,
        ST_HDR,
        ST_FETCH,
        ST_WAIT,
        ST_R,
        ST_G,
        ST_B,
        ST_TRAILER,
        ST_DONE
    } tx_state_t;

endpackage

// File: rtl/frame_tx_serializer.sv
// Streams one frame (0xAA, R/G/B per pixel, 0x55) from the frame buffer into the UART TX FIFO.
// Latency: start byte pushed the cycle after start is sampled, then 5 cycles per pixel.
// Backpressure: full stalls the byte-push states with push low; fetch/wait always complete.
module frame_tx_serializer #(
    parameter int DATA_WIDTH      = 8,
    parameter int TOTAL_PIXELS    = 40800,
    parameter int PIXEL_CNT_WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    output logic                       busy,
    output logic                       frame_done,
    output logic                       rd_en,
    output logic [PIXEL_CNT_WIDTH-1:0] rd_addr,
    input  logic [3*DATA_WIDTH-1:0]    rd_data,
    input  logic                       full,
    output logic                       push,
    output logic [DATA_WIDTH-1:0]      push_data,
    output logic [PIXEL_CNT_WIDTH-1:0] pixel_cnt
);
    import uart_frame_pkg::*;

    localparam logic [PIXEL_CNT_WIDTH-1:0] LAST_PIX = PIXEL_CNT_WIDTH'(TOTAL_PIXELS - 1);
    localparam logic [PIXEL_CNT_WIDTH-1:0] CNT_ONE  = PIXEL_CNT_WIDTH'(1);

    tx_state_t               state;
    tx_state_t               state_nxt;
    logic [3*DATA_WIDTH-1:0] pixel_q;

    // Status decoded straight from the state register
    assign busy       = (state != ST_IDLE);
    assign frame_done = (state == ST_DONE);
    assign rd_addr    = pixel_cnt;

    // State, pixel capture and pixel counter; all hold while a byte state is stalled
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            pixel_q   <= '0;
            pixel_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_WAIT) begin
                pixel_q <= rd_data;
            end
            if (state == ST_B && !full) begin
                pixel_cnt <= (pixel_cnt < LAST_PIX) ? pixel_cnt + CNT_ONE : '0;
            end
        end
    end

    // Next-state and FIFO/buffer strobes; push only ever asserted with full low
    always_comb begin
        state_nxt = state;
        push      = 1'b0;
        push_data = '0;
        rd_en     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) state_nxt = ST_HDR;
            end
            ST_HDR: begin
                push      = ~full;
                push_data = DATA_WIDTH'(START_BYTE);
                if (!full) state_nxt = ST_FETCH;
            end
            ST_FETCH: begin
                rd_en     = 1'b1;
                state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                state_nxt = ST_R;
            end
            ST_R: begin
                push      = ~full;
                push_data = pixel_q[3*DATA_WIDTH-1 -: DATA_WIDTH];
                if (!full) state_nxt = ST_G;
            end
            ST_G: begin
                push      = ~full;
                push_data = pixel_q[2*DATA_WIDTH-1 -: DATA_WIDTH];
                if (!full) state_nxt = ST_B;
            end
            ST_B: begin
                push      = ~full;
                push_data = pixel_q[DATA_WIDTH-1:0];
                if (!full) state_nxt = (pixel_cnt < LAST_PIX) ? ST_FETCH : ST_TRAILER;
            end
            ST_TRAILER: begin
                push      = ~full;
                push_data = DATA_WIDTH'(END_BYTE);
                if (!full) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_frame_tx_serializer.sv
// Bench for frame_tx_serializer: 4-pixel and 1-pixel instances, scoreboard of expected bytes.
// Latency: checks start-to-frame_done distance and stall/resume timing.
// Backpressure: drives full steady, random and held-high during a colour byte.
module tb_frame_tx_serializer;

    logic        clk = 1'b0;
    logic        reset;

    // 4-pixel instance
    logic        start, full;
    logic        busy, frame_done, rd_en, push;
    logic [15:0] rd_addr, pixel_cnt;
    logic [23:0] rd_data;
    logic [7:0]  push_data;

    // 1-pixel instance
    logic        start1, full1;
    logic        busy1, frame_done1, rd_en1, push1;
    logic [15:0] rd_addr1, pixel_cnt1;
    logic [23:0] rd_data1;
    logic [7:0]  push_data1;

    logic [23:0] mem [4];
    logic [23:0] mem1;

    logic [7:0]  exp_q  [$];
    logic [7:0]  exp_q1 [$];

    int n_chk  = 0;
    int n_pass = 0;
    int nbytes = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int done_cnt1 = 0;
    int cycle = 0;

    always #5 clk = ~clk;

    frame_tx_serializer #(.DATA_WIDTH(8), .TOTAL_PIXELS(4), .PIXEL_CNT_WIDTH(16)) u_dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .frame_done(frame_done),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .full(full),
        .push(push), .push_data(push_data), .pixel_cnt(pixel_cnt)
    );

    frame_tx_serializer #(.DATA_WIDTH(8), .TOTAL_PIXELS(1), .PIXEL_CNT_WIDTH(16)) u_dut1 (
        .clk(clk), .reset(reset), .start(start1), .busy(busy1), .frame_done(frame_done1),
        .rd_en(rd_en1), .rd_addr(rd_addr1), .rd_data(rd_data1), .full(full1),
        .push(push1), .push_data(push_data1), .pixel_cnt(pixel_cnt1)
    );

    // Frame buffer models: data returned one cycle after the read strobe
    always @(posedge clk) begin
        if (rd_en)  rd_data  <= mem[rd_addr[1:0]];
        if (rd_en1) rd_data1 <= mem1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Scoreboard side: compare every pushed byte against the queue head
    task automatic monitor();
        logic [7:0] b;
        if (full) chk("push_while_full", {31'd0, push}, 32'd0);
        if (push) begin
            if (exp_q.size() == 0) chk("unexpected_push", {31'd0, push}, 32'd0);
            else begin
                b = exp_q.pop_front();
                chk("byte", {24'd0, push_data}, {24'd0, b});
                nbytes++;
            end
        end
        if (frame_done) begin
            done_cnt++;
            done_cyc = cycle;
        end
        if (busy1) chk("pix1_cnt", {16'd0, pixel_cnt1}, 32'd0);
        if (push1) begin
            if (exp_q1.size() == 0) chk("unexpected_push1", {31'd0, push1}, 32'd0);
            else begin
                b = exp_q1.pop_front();
                chk("byte1", {24'd0, push_data1}, {24'd0, b});
            end
        end
        if (frame_done1) done_cnt1++;
    endtask

    // One clock: sample at the falling edge, return 1 time unit after the rising edge
    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        cycle++;
        #1;
    endtask

    task automatic load_expected();
        exp_q.push_back(8'hAA);
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(mem[i][23:16]);
            exp_q.push_back(mem[i][15:8]);
            exp_q.push_back(mem[i][7:0]);
        end
        exp_q.push_back(8'h55);
    endtask

    // Start a frame and run it to frame_done, optionally with random full and a stray start
    task automatic run_frame(input bit rnd, input bit restart, input bit chk_lat);
        int d0, c0, base, cyc;
        bit pulsed;
        load_expected();
        d0 = done_cnt; base = nbytes; c0 = cycle; cyc = 0; pulsed = 0;
        start = 1'b1;
        while (done_cnt == d0 && cyc < 400) begin
            tick();
            start = 1'b0;
            full  = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
            if (restart && !pulsed && (nbytes - base) >= 7) begin
                start  = 1'b1;
                pulsed = 1'b1;
            end
            cyc++;
        end
        full = 1'b0;
        start = 1'b0;
        chk("done_seen", done_cnt - d0, 32'd1);
        if (chk_lat) chk("done_latency", done_cyc - c0 - 1, 32'd22);
        for (int i = 0; i < 6; i++) tick();
        chk("done_once", done_cnt - d0, 32'd1);
        chk("frame_bytes", nbytes - base, 32'd14);
        chk("queue_empty", exp_q.size(), 32'd0);
    endtask

    initial begin
        int base, guard;
        mem[0] = 24'h112233; mem[1] = 24'h445566; mem[2] = 24'h778899; mem[3] = 24'hAABBCC;
        mem1 = 24'h00FF00;
        start = 1'b0; full = 1'b0; start1 = 1'b0; full1 = 1'b0;
        reset = 1'b0;
        #1;
        repeat (3) tick();
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, frame_done}, 32'd0);
        chk("rst_push", {31'd0, push}, 32'd0);
        chk("rst_pdata", {24'd0, push_data}, 32'd0);
        chk("rst_rd_en", {31'd0, rd_en}, 32'd0);
        chk("rst_rd_addr", {16'd0, rd_addr}, 32'd0);
        chk("rst_pix_cnt", {16'd0, pixel_cnt}, 32'd0);
        reset = 1'b1;
        repeat (2) tick();

        // Plain frame with latency check
        run_frame(1'b0, 1'b0, 1'b1);
        // Same frame under random backpressure
        run_frame(1'b1, 1'b0, 1'b0);
        // Stray start mid-frame must be ignored
        run_frame(1'b0, 1'b1, 1'b0);

        // Stall 10 cycles in the G state of pixel 1
        load_expected();
        base = nbytes; guard = 0;
        start = 1'b1;
        while ((nbytes - base) < 5 && guard < 100) begin
            tick();
            start = 1'b0;
            guard++;
        end
        full = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("stall_push", {31'd0, push}, 32'd0);
            chk("stall_cnt", {16'd0, pixel_cnt}, 32'd1);
            chk("stall_busy", {31'd0, busy}, 32'd1);
        end
        full = 1'b0;
        #1;
        chk("resume_push", {31'd0, push}, 32'd1);
        chk("resume_g", {24'd0, push_data}, 32'h55);
        guard = 0;
        while (exp_q.size() != 0 && guard < 100) begin
            tick();
            guard++;
        end
        chk("stall_drain", exp_q.size(), 32'd0);
        repeat (4) tick();

        // Reset during pixel 1's R state
        load_expected();
        base = nbytes; guard = 0;
        start = 1'b1;
        while ((nbytes - base) < 4 && guard < 100) begin
            tick();
            start = 1'b0;
            guard++;
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("pre_rst_push", {31'd0, push}, 32'd1);
        chk("pre_rst_r", {24'd0, push_data}, 32'h44);
        reset = 1'b0;
        #1;
        chk("arst_push", {31'd0, push}, 32'd0);
        chk("arst_pdata", {24'd0, push_data}, 32'd0);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_rd_en", {31'd0, rd_en}, 32'd0);
        chk("arst_cnt", {16'd0, pixel_cnt}, 32'd0);
        chk("arst_done", {31'd0, frame_done}, 32'd0);
        exp_q.delete();
        repeat (2) tick();
        reset = 1'b1;
        repeat (2) tick();
        run_frame(1'b0, 1'b0, 1'b0);

        // Single-pixel instance
        exp_q1.push_back(8'hAA); exp_q1.push_back(8'h00); exp_q1.push_back(8'hFF);
        exp_q1.push_back(8'h00); exp_q1.push_back(8'h55);
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        guard = 0;
        while (done_cnt1 == 0 && guard < 100) begin
            tick();
            guard++;
        end
        repeat (4) tick();
        chk("pix1_done", done_cnt1, 32'd1);
        chk("pix1_queue", exp_q1.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
